// File: rtl/pci_arbiter.sv
// pci_arbiter: round-robin PCI bus arbiter with registered active-low grants and a turnaround gap.
// Define ARB_PARK_EN to park the idle bus on PARK_ID; the default build leaves all grants high when idle.
module pci_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int ID_W      = 2,
  parameter int TIMEOUT   = 16,
  parameter int PARK_ID   = 0
) (
  input  logic                 CLK,
  input  logic                 REST,
  input  logic [N_MASTERS-1:0] REQ,
  input  logic                 FRAME,
  input  logic                 IRDY,
  output logic [N_MASTERS-1:0] GNT,
  output logic [ID_W-1:0]      OWNER,
  output logic                 GNT_VALID,
  output logic                 TIMEOUT_ERR
);

`ifdef ARB_PARK_EN
  localparam bit PARK_EN = 1'b1;
`else
  localparam bit PARK_EN = 1'b0;
`endif

  localparam int               CNT_W    = 5;
  localparam logic [ID_W-1:0]  PARK_IDX = ID_W'(PARK_ID);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, TURN} state_e;

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [ID_W-1:0]      winner, cand;
  logic                 bus_idle, any_req, other_req, parked, timed_out;

  function automatic logic [N_MASTERS-1:0] onehot(input logic [ID_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign bus_idle  = FRAME & IRDY;
  assign any_req   = ~&REQ;
  assign other_req = |(~REQ & ~onehot(owner_q));
  assign parked    = (state_q == IDLE) && !(&gnt_q);
  assign timed_out = (state_q == GRANT) && FRAME && !REQ[owner_q] && (cnt_q == CNT_LAST);

  // Scan downward so the nearest requester after last_q is the one left in winner.
  always_comb begin
    winner = last_q;
    cand   = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      cand = ID_W'((int'(last_q) + k) % N_MASTERS);
      if (!REQ[cand]) winner = cand;
    end
  end

  always_ff @(posedge CLK) begin
    if (REST) begin
      state_q       <= IDLE;
      gnt_q         <= '1;
      owner_q       <= '0;
      last_q        <= ID_W'(N_MASTERS - 1);
      cnt_q         <= '0;
      gnt_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      gnt_valid_q   <= gnt_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // A parked master only keeps the bus without a turnaround if it is also the round-robin winner.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (PARK_EN && parked && !FRAME) begin
          state_d = BUSY;
        end else if (any_req && bus_idle && (!(PARK_EN && parked) || winner == PARK_IDX)) begin
          state_d = GRANT;
          owner_d = winner;
          last_d  = winner;
        end else if (PARK_EN && !any_req && bus_idle) begin
          owner_d = PARK_IDX;
        end
      end
      GRANT: begin
        if (!FRAME) begin
          state_d = BUSY;
        end else if (REQ[owner_q] || timed_out) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus_idle) state_d = TURN;
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cnt_d = (state_q == GRANT && state_d == GRANT) ? cnt_q + CNT_W'(1) : '0;
  end

  // Once released during a transaction the grant stays released until the next arbitration.
  always_comb begin
    gnt_d = '1;
    unique case (state_d)
      GRANT: begin
        gnt_d = (state_q == GRANT) ? gnt_q : ~onehot(owner_d);
      end
      BUSY: begin
        if (state_q != BUSY || (!REQ[owner_q] && !other_req)) gnt_d = gnt_q;
      end
      IDLE: begin
        if (PARK_EN && !any_req && (bus_idle || parked)) gnt_d = ~onehot(PARK_IDX);
      end
      default: begin
        gnt_d = '1;
      end
    endcase
    gnt_valid_d   = ~&gnt_d;
    timeout_err_d = timed_out;
  end

  assign GNT         = gnt_q;
  assign OWNER       = owner_q;
  assign GNT_VALID   = gnt_valid_q;
  assign TIMEOUT_ERR = timeout_err_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// tb_pci_arbiter: directed and randomized stimulus for pci_arbiter, checked every cycle
// against a rule-level model of who should hold the bus grant.
`timescale 1ns/1ps
module tb_pci_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TMO = 16;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_TX   = 2;
  localparam int M_TURN = 3;

  logic         clk;
  logic         rest;
  logic [N-1:0] req;
  logic         frame;
  logic         irdy;
  logic [N-1:0] gnt;
  logic [IDW-1:0] owner;
  logic         gntValid;
  logic         timeoutErr;

  int checks   = 0;
  int failures = 0;

  int mMode;
  int mHolder;
  int mOwner;
  int mLast;
  int mWait;
  bit mErr;

  pci_arbiter #(
    .N_MASTERS(N),
    .ID_W(IDW),
    .TIMEOUT(TMO),
    .PARK_ID(0)
  ) dut (
    .CLK(clk),
    .REST(rest),
    .REQ(req),
    .FRAME(frame),
    .IRDY(irdy),
    .GNT(gnt),
    .OWNER(owner),
    .GNT_VALID(gntValid),
    .TIMEOUT_ERR(timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h time=%0t", tag, observed, expected, $time);
    end
  endtask

  // First requester (active-low) found going round from the master after last.
  function automatic int pickWinner(input logic [N-1:0] r, input int last);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (!r[idx[IDW-1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic updateModel(input logic [N-1:0] r, input logic f, input logic i, input logic rst);
    int w;
    logic busIdle;
    logic [N-1:0] others;
    mErr = 1'b0;
    if (rst) begin
      mMode   = M_IDLE;
      mHolder = -1;
      mOwner  = 0;
      mLast   = N - 1;
      mWait   = 0;
    end else begin
      busIdle = f & i;
      w = pickWinner(r, mLast);
      others = ~r;
      others[mOwner[IDW-1:0]] = 1'b0;
      case (mMode)
        M_IDLE: begin
          if (w >= 0 && busIdle) begin
            mHolder = w;
            mOwner  = w;
            mLast   = w;
            mWait   = 0;
            mMode   = M_WAIT;
          end
        end
        M_WAIT: begin
          mWait++;
          if (!f) begin
            mMode = M_TX;
          end else if (r[mOwner[IDW-1:0]]) begin
            mHolder = -1;
            mMode   = M_IDLE;
          end else if (mWait == TMO) begin
            mHolder = -1;
            mErr    = 1'b1;
            mMode   = M_IDLE;
          end
        end
        M_TX: begin
          if (busIdle) begin
            mHolder = -1;
            mMode   = M_TURN;
          end else if (mHolder >= 0 && (r[mOwner[IDW-1:0]] || (|others))) begin
            mHolder = -1;
          end
        end
        default: begin
          mMode = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic f, input logic i, input logic rst);
    logic [N-1:0] expGnt;
    @(negedge clk);
    req   = r;
    frame = f;
    irdy  = i;
    rest  = rst;
    @(posedge clk);
    #1;
    updateModel(r, f, i, rst);
    expGnt = '1;
    if (mHolder >= 0) expGnt[mHolder[IDW-1:0]] = 1'b0;
    checkOutput("gnt", 32'(gnt), 32'(expGnt));
    checkOutput("owner", 32'(owner), 32'(mOwner));
    checkOutput("gnt_valid", 32'(gntValid), 32'(mHolder >= 0));
    checkOutput("timeout_err", 32'(timeoutErr), 32'(mErr));
  endtask

  initial begin
    logic [N-1:0] rr;
    logic f;
    logic i;
    logic rst;
    int framePct;
    int togglePct;
    int txLeft;
    bit tail;

    rest  = 1'b1;
    req   = '1;
    frame = 1'b1;
    irdy  = 1'b1;
    txLeft = 0;
    tail   = 1'b0;
    framePct  = 0;
    togglePct = 0;

    // Reset with every master requesting, then master 0 wins first.
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b1);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b1);
    applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);

    // Round-robin: each owner runs a short transaction, then turnaround and idle.
    for (int n = 0; n < 5; n++) begin
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0);
    end

    // Timeout: master 2 requests alone and never starts a transaction.
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1);
    for (int n = 0; n < 20; n++) applyStimulus(4'b1011, 1'b1, 1'b1, 1'b0);

    // Withdrawal before FRAME.
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1);
    applyStimulus(4'b1110, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0);

    // Preemption of master 1 by master 3 mid-transaction.
    applyStimulus(4'b1111, 1'b1, 1'b1, 1'b1);
    applyStimulus(4'b1101, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b1101, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b1101, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0101, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0101, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0101, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0101, 1'b1, 1'b1, 1'b0);

    // Random traffic with changing request churn and FRAME eagerness.
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(2))
          0:       framePct = 0;
          1:       framePct = 15;
          default: framePct = 70;
        endcase
        togglePct = ($urandom_range(1) == 0) ? 3 : 25;
      end
      rr = req;
      for (int j = 0; j < N; j++) begin
        if (int'($urandom_range(99)) < togglePct) rr[j] = ~rr[j];
      end
      rst = ($urandom_range(199) == 0);
      if (txLeft > 0) begin
        f = 1'b0;
        i = 1'b0;
        if ($urandom_range(3) == 0) i = 1'b1;
        txLeft--;
        if (txLeft == 0) tail = 1'b1;
      end else if (tail) begin
        f = 1'b1;
        i = 1'b0;
        tail = 1'b0;
      end else if (mHolder >= 0 && int'($urandom_range(99)) < framePct) begin
        f = 1'b0;
        i = 1'b1;
        txLeft = int'($urandom_range(4));
        if (txLeft == 0) tail = 1'b1;
      end else begin
        f = 1'b1;
        i = 1'b1;
      end
      applyStimulus(rr, f, i, rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pci_arbiter.md
Name: pci_arbiter

Overview:
Central PCI bus arbiter. It shares one PCI bus (AD/CBE/FRAME/IRDY) among up to N_MASTERS initiators using active-low REQ/GNT pairs. The arbitration policy is round-robin. It watches FRAME/IRDY to track bus ownership, and it guarantees a one-cycle gap with all grants released between owners. It sits beside the Device_new targets on the shared bus and sequences which initiator may drive FRAME next.

Parameters:
N_MASTERS, 4, number of requesting initiators (2..8)
ID_W, 2, width of OWNER (must satisfy 2**ID_W >= N_MASTERS)
TIMEOUT, 16, cycles a granted master has to assert FRAME before the grant is revoked (1..31)
PARK_ID, 0, master parked on when ARB_PARK_EN is defined

Ports:
CLK  input  1  bus clock; all logic on posedge
REST  input  1  synchronous reset, active-high
REQ  input  N_MASTERS  per-master bus request, active-low
FRAME  input  1  PCI FRAME, active-low
IRDY  input  1  PCI IRDY, active-low
GNT  output  N_MASTERS  per-master grant, active-low, registered
OWNER  output  ID_W  index of the current or last granted master, registered
GNT_VALID  output  1  high while any GNT bit is low
TIMEOUT_ERR  output  1  one-cycle pulse when a grant is revoked for timeout

Behaviour:
- One clock (CLK). Reset is synchronous and active-high on REST, sampled at posedge CLK.
- Reset values: GNT all 1s; OWNER 0; GNT_VALID 0; TIMEOUT_ERR 0; state IDLE; round-robin pointer LAST = N_MASTERS-1, so master 0 wins first; timeout counter 0.
- Reset mid-transaction releases all grants on that edge. The arbiter does not wait for FRAME.
- Bus idle: BUS_IDLE = FRAME & IRDY, sampled at posedge.
- Winner selection: the first master with REQ low, searching LAST+1, LAST+2, ... modulo N_MASTERS. LAST updates to the winner when a grant is issued.
- State IDLE:
  - All GNT high.
  - If any REQ is low and BUS_IDLE, go to GRANT. GNT[winner] goes low on the same edge, and OWNER = winner.
  - If a request is pending but the bus is busy (a transaction started before reset or by a parked master), stay in IDLE.
- State GRANT:
  - Timeout counter increments every cycle.
  - FRAME sampled low: go to BUSY and clear the counter.
  - Else if REQ[OWNER] is high: release GNT and go to IDLE.
  - Else if counter == TIMEOUT-1: release GNT, pulse TIMEOUT_ERR, go to IDLE. LAST keeps the owner's index, so that master gets lowest priority next round.
- State BUSY:
  - GNT[OWNER] stays low while REQ[OWNER] is low and no other REQ is low.
  - If any other master requests, GNT[OWNER] is released immediately. The owner finishes its current transaction; the arbiter never aborts FRAME.
  - When BUS_IDLE is sampled, go to TURN.
- State TURN: exactly one cycle with all GNT high (turnaround), then go to IDLE.
- At most one GNT bit is low at any time. Every change of grant holder passes through at least one cycle with all GNT high.
- Simultaneous requests: the round-robin order decides. Requests that appear during BUSY or TURN are only considered in IDLE.
- A REQ pulse shorter than one cycle that is not sampled at a posedge is ignored.
- GNT_VALID = ~&GNT, registered alongside GNT.

Optional Feature:
ARB_PARK_EN:
- Defined:
  - In IDLE with no REQ low and BUS_IDLE, GNT[PARK_ID] is driven low (parked); OWNER = PARK_ID; GNT_VALID = 1.
  - If PARK_ID itself then requests, go directly to GRANT without releasing GNT.
  - If another master requests, release the park grant for one cycle, then grant the winner.
  - A parked master asserting FRAME without REQ is tracked as BUSY.
  - LAST is not updated by parking.
- Undefined: all GNT stay high in IDLE with no requests.

Test Plan:
- Reset: REST=1 for 2 cycles with REQ=4'b0000 -> GNT=4'b1111, GNT_VALID=0, OWNER=0. After release, the next edge gives GNT=4'b1110.
- Round-robin: REQ=4'b0000 held; each master runs one FRAME transaction and the bus returns idle -> grant order 0,1,2,3,0. Each handover shows one all-high TURN cycle and one IDLE cycle.
- Timeout: REQ[2] low only, FRAME never asserted -> GNT[2] low for 16 cycles, then GNT=4'b1111 and a single TIMEOUT_ERR pulse. Next grant goes to 2 only if no other REQ is low.
- Preemption: master 1 in BUSY, then REQ[3] goes low -> GNT[1] high next edge while FRAME stays low. After FRAME=IRDY=1: TURN, IDLE, then GNT=4'b0111.
- Request withdrawal: GNT[0] low in GRANT, REQ[0] goes high before FRAME -> GNT=4'b1111 next edge, no TIMEOUT_ERR.
- ARB_PARK_EN, PARK_ID=0: no requests -> GNT=4'b1110. REQ[2] low -> one cycle of 4'b1111, then 4'b1011.
